// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank checker.
//   state_t : checker FSM encoding
//   phase_t : current pass (write pattern / read back and compare)
//   LFSR_W  : width of the pseudo-random generator used for request gaps
package jtsdram_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_REQ,
    ST_WAIT,
    ST_COMPLETE,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_WR = 1'b0,
    PH_RD = 1'b1
  } phase_t;

endpackage

// File: rtl/jtsdram_bank_chk_if.sv
// Request port between the bank checker (master) and the SDRAM controller (slave).
//   req/rnw/addr/wrdata : request issued by the checker
//   ack                 : controller accepted the request
//   rdy/din             : access complete, read data valid on din
interface jtsdram_bank_chk_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic          req;
  logic          rnw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wrdata;
  logic          ack;
  logic          rdy;
  logic [DW-1:0] din;

  modport master (output req, rnw, addr, wrdata, input  ack, rdy, din);
  modport slave  (input  req, rnw, addr, wrdata, output ack, rdy, din);
endinterface

// File: rtl/jtsdram_rnd.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), advancing when i_adv is high.
//   clk, rst : clock, asynchronous active-high reset
//   i_adv    : step the generator this cycle
//   o_rnd    : low OW bits of the generator state
module jtsdram_rnd
  import jtsdram_pkg::*;
#(
  parameter int OW = LFSR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [OW-1:0] o_rnd
);

  logic [LFSR_W-1:0] r_lfsr;

  // Non-zero reset value: the all-zero state would lock the LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (i_adv) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign o_rnd = r_lfsr[OW-1:0];

endmodule

// File: rtl/jtsdram_bank_chk.sv
// SDRAM bank checker: writes ref(a) = seed ^ a over 0..last_addr, reads it back and
// compares, logging mismatches and timeouts.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : (re)start a run, clears results in the same cycle
//   wr_en           : 1 = write pass then read pass, 0 = read pass only
//   slow, hold      : random inter-request gaps / block new requests
//   seed, last_addr : pattern seed and range end, sampled at start
//   bus             : controller request port (master side)
//   busy, done      : run in progress / run finished (held until start)
//   bad, timeout    : sticky error flags for this run
//   err_cnt         : saturating count of mismatches + timeouts
//   first_bad       : address of the first error, 0 if none
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int ERRW  = 8,
  parameter int GAPW  = 4,
  parameter int TOUTW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_en,
  input  logic             slow,
  input  logic             hold,
  input  logic [DW-1:0]    seed,
  input  logic [AW-1:0]    last_addr,
  jtsdram_bank_chk_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             bad,
  output logic             timeout,
  output logic [ERRW-1:0]  err_cnt,
  output logic [AW-1:0]    first_bad
);

  function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] s, input logic [AW-1:0] a);
    return s ^ DW'(a);
  endfunction

  state_t           r_state, w_state_nx;
  phase_t           r_phase;
  logic [AW-1:0]    r_addr, r_last, r_first_bad;
  logic [DW-1:0]    r_seed, r_din;
  logic [GAPW-1:0]  r_gap;
  logic [TOUTW-1:0] r_tout;
  logic [ERRW-1:0]  r_err_cnt;
  logic             r_bad, r_timeout, r_tmo_hit;
  logic [GAPW-1:0]  w_rnd;
  logic             w_take_rdy, w_tmo, w_mis, w_last, w_tout_sat;

  jtsdram_rnd #(.OW(GAPW)) u_rnd (
    .clk   (clk),
    .rst   (rst),
    .i_adv (1'b1),
    .o_rnd (w_rnd)
  );

  assign w_last     = (r_addr == r_last);
  assign w_tout_sat = &r_tout;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nx = r_state;
    w_take_rdy = 1'b0;
    w_tmo      = 1'b0;
    w_mis      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: ;
      ST_GAP:
        if (r_gap == '0 && !hold) w_state_nx = ST_REQ;
      ST_REQ:
        if (bus.ack && bus.rdy) begin
          w_take_rdy = 1'b1;
          w_state_nx = ST_COMPLETE;
        end else if (bus.ack) begin
          w_state_nx = ST_WAIT;
        end else if (w_tout_sat) begin
          w_tmo      = 1'b1;
          w_state_nx = ST_COMPLETE;
        end
      ST_WAIT:
        if (bus.rdy) begin
          w_take_rdy = 1'b1;
          w_state_nx = ST_COMPLETE;
        end else if (w_tout_sat) begin
          w_tmo      = 1'b1;
          w_state_nx = ST_COMPLETE;
        end
      ST_COMPLETE: begin
        // Case inequality so an undriven/X read counts as a mismatch.
        w_mis = (r_phase == PH_RD) && !r_tmo_hit && (r_din !== ref_data(r_seed, r_addr));
        if (!w_last || r_phase == PH_WR) w_state_nx = ST_GAP;
        else                             w_state_nx = ST_DONE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // start overrides everything: the aborted access is simply forgotten.
    if (start) w_state_nx = ST_GAP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_WR;
      r_addr      <= '0;
      r_last      <= '0;
      r_first_bad <= '0;
      r_seed      <= '0;
      r_din       <= '0;
      r_gap       <= '0;
      r_tout      <= '0;
      r_err_cnt   <= '0;
      r_bad       <= 1'b0;
      r_timeout   <= 1'b0;
      r_tmo_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (start) begin
        r_addr      <= '0;
        r_phase     <= wr_en ? PH_WR : PH_RD;
        r_seed      <= seed;
        r_last      <= last_addr;
        r_first_bad <= '0;
        r_err_cnt   <= '0;
        r_bad       <= 1'b0;
        r_timeout   <= 1'b0;
        r_tmo_hit   <= 1'b0;
      end else begin
        if (r_state == ST_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;

        // Timeout counter restarts with each new request, holds at saturation.
        if (r_state == ST_GAP && w_state_nx == ST_REQ) begin
          r_tout    <= '0;
          r_tmo_hit <= 1'b0;
        end else if ((r_state == ST_REQ || r_state == ST_WAIT) && !w_tout_sat) begin
          r_tout <= r_tout + 1'b1;
        end

        if (w_take_rdy) r_din <= bus.din;
        if (w_tmo) begin
          r_tmo_hit <= 1'b1;
          r_timeout <= 1'b1;
        end

        if (w_tmo || w_mis) begin
          if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_bad) begin
            r_bad       <= 1'b1;
            r_first_bad <= r_addr;
          end
        end

        if (r_state == ST_COMPLETE) begin
          if (!w_last) begin
            r_addr <= r_addr + 1'b1;
          end else if (r_phase == PH_WR) begin
            r_phase <= PH_RD;
            r_addr  <= '0;
          end
        end
      end

      // Gap length is chosen on every entry into GAP, including a restart.
      if (w_state_nx == ST_GAP && (start || r_state == ST_COMPLETE))
        r_gap <= slow ? w_rnd : '0;
    end
  end

  assign bus.req    = (r_state == ST_REQ);
  assign bus.rnw    = (r_phase == PH_RD);
  assign bus.addr   = r_addr;
  assign bus.wrdata = ref_data(r_seed, r_addr);

  assign busy      = (r_state == ST_GAP) || (r_state == ST_REQ) ||
                     (r_state == ST_WAIT) || (r_state == ST_COMPLETE);
  assign done      = (r_state == ST_DONE);
  assign bad       = r_bad;
  assign timeout   = r_timeout;
  assign err_cnt   = r_err_cnt;
  assign first_bad = r_first_bad;

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Directed bench for jtsdram_bank_chk with a small controller model and a scoreboard
// of expected requests (pushed at start, popped as the DUT issues requests).
module tb_jtsdram_bank_chk;
  localparam int AW = 4, DW = 16, ERRW = 8, GAPW = 4, TOUTW = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_en = 1'b0, slow = 1'b0, hold = 1'b0;
  logic [DW-1:0]   seed = '0;
  logic [AW-1:0]   last_addr = '0;
  logic            busy, done, bad, timeout;
  logic [ERRW-1:0] err_cnt;
  logic [AW-1:0]   first_bad;

  jtsdram_bank_chk_if #(.AW(AW), .DW(DW)) bus ();

  jtsdram_bank_chk #(.AW(AW), .DW(DW), .ERRW(ERRW), .GAPW(GAPW), .TOUTW(TOUTW)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .slow(slow), .hold(hold),
    .seed(seed), .last_addr(last_addr), .bus(bus), .busy(busy), .done(done),
    .bad(bad), .timeout(timeout), .err_cnt(err_cnt), .first_bad(first_bad)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [2**AW];
  int n_vec = 0, n_err = 0;
  int corrupt_a = -1, corrupt_b = -1, drop_addr = -1, abort_addr = -1, lat = 0;
  int max_int, min_int, tmo_ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input logic w, input logic [AW-1:0] last, input logic [DW-1:0] s);
    exp_q.delete();
    if (w) for (int a = 0; a <= int'(last); a++) exp_q.push_back({1'b0, AW'(a), s ^ DW'(a)});
    for (int a = 0; a <= int'(last); a++) exp_q.push_back({1'b1, AW'(a), {DW{1'b0}}});
  endtask

  task automatic go(input logic w, input logic [AW-1:0] last, input logic [DW-1:0] s);
    wr_en = w; last_addr = last; seed = s;
    plan(w, last, s);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Controller model: acks every request immediately, returns rdy lat+1 cycles later.
  task automatic serve(input int budget);
    int pend, drop_t, last_req;
    logic [DW-1:0] pend_data, rd;
    exp_t e;
    bit finished;
    pend = -1; drop_t = -1; last_req = -1; finished = 1'b0;
    tmo_ticks = -1; max_int = 0; min_int = 1000;
    for (int cyc = 0; cyc < budget; cyc++) begin
      bus.ack = 1'b0; bus.rdy = 1'b0; bus.din = '0;
      if (done) begin finished = 1'b1; break; end
      if (drop_t >= 0) begin
        drop_t++;
        if (timeout && tmo_ticks < 0) tmo_ticks = drop_t;
      end
      if (pend == 0) begin bus.rdy = 1'b1; bus.din = pend_data; pend = -1; end
      else if (pend > 0) pend--;
      if (bus.req) begin
        if (last_req >= 0) begin
          if (cyc - last_req > max_int) max_int = cyc - last_req;
          if (cyc - last_req < min_int) min_int = cyc - last_req;
        end
        last_req = cyc;
        check("sb_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_rnw", bus.rnw, e.rnw);
          check("req_addr", bus.addr, e.addr);
          if (!e.rnw) check("req_wrdata", bus.wrdata, e.data);
        end
        if (!bus.rnw) mem[bus.addr] = bus.wrdata;
        rd = mem[bus.addr];
        if (int'(bus.addr) == corrupt_a || int'(bus.addr) == corrupt_b) rd = rd ^ 16'h0100;
        bus.ack = 1'b1;
        if (bus.rnw && int'(bus.addr) == abort_addr) begin
          check("pre_abort_err", err_cnt, 1);
          tick();
          bus.ack = 1'b0;
          plan(wr_en, last_addr, seed);
          start = 1'b1;
          tick();
          start = 1'b0;
          check("abort_err_clr", err_cnt, 0);
          check("abort_bad_clr", bad, 0);
          check("abort_busy", busy, 1);
          // Late rdy of the aborted read, with data that would miscompare.
          bus.rdy = 1'b1; bus.din = ~(seed ^ 16'h0007);
          corrupt_a = -1; abort_addr = -1; last_req = -1;
          tick();
          continue;
        end else if (bus.rnw && int'(bus.addr) == drop_addr) begin
          drop_t = 0;
        end else begin
          pend = lat; pend_data = rd;
        end
      end
      tick();
    end
    bus.ack = 1'b0; bus.rdy = 1'b0;
    check("run_done", finished, 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int req_cnt;
    bus.ack = 1'b0; bus.rdy = 1'b0; bus.din = '0;

    // Reset state
    repeat (3) tick();
    check("rst_req", bus.req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bad", bad, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first_bad", first_bad, 0);
    rst = 1'b0;
    tick();

    // 1: clean write + read pass, no gaps
    go(1'b1, 4'd15, 16'hA5A5);
    serve(2000);
    check("t1_bad", bad, 0);
    check("t1_err", err_cnt, 0);
    check("t1_busy", busy, 0);
    check("t1_interval", (max_int == 4 && min_int == 4), 1);

    // 2: corrupted reads at 5 and 9
    corrupt_a = 5; corrupt_b = 9;
    go(1'b1, 4'd15, 16'hA5A5);
    serve(2000);
    check("t2_err", err_cnt, 2);
    check("t2_first_bad", first_bad, 5);
    check("t2_bad", bad, 1);
    check("t2_timeout", timeout, 0);
    corrupt_a = -1; corrupt_b = -1;

    // Reset clears a finished run's results
    rst = 1'b1;
    tick();
    check("rst2_bad", bad, 0);
    check("rst2_err", err_cnt, 0);
    check("rst2_done", done, 0);
    rst = 1'b0;
    tick();

    // 3: read at addr 3 never completes
    drop_addr = 3;
    go(1'b1, 4'd15, 16'hA5A5);
    serve(2000);
    check("t3_timeout", timeout, 1);
    check("t3_first_bad", first_bad, 3);
    check("t3_err", err_cnt, 1);
    check("t3_tmo_latency", (tmo_ticks >= 15 && tmo_ticks <= 16), 1);
    drop_addr = -1;

    // 4: restart mid read pass at addr 7 with a late rdy
    corrupt_a = 5; abort_addr = 7;
    go(1'b1, 4'd15, 16'hA5A5);
    serve(3000);
    check("t4_err", err_cnt, 0);
    check("t4_bad", bad, 0);
    check("t4_first_bad", first_bad, 0);

    // 5: hold blocks requests; random gaps bounded
    slow = 1'b1; hold = 1'b1;
    go(1'b1, 4'd15, 16'h3C3C);
    req_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req) req_cnt++;
      tick();
    end
    check("t5_req_under_hold", req_cnt, 0);
    check("t5_busy_hold", busy, 1);
    hold = 1'b0;
    serve(3000);
    check("t5_err", err_cnt, 0);
    check("t5_max_gap", (max_int <= 4 + 15), 1);
    check("t5_some_gap", (max_int > 4), 1);
    slow = 1'b0;

    // 6: single read, ack and rdy together
    go(1'b0, 4'd0, 16'h3C3C);
    for (int i = 0; i < 20 && !bus.req; i++) tick();
    check("t6_req", bus.req, 1);
    check("t6_rnw", bus.rnw, 1);
    check("t6_addr", bus.addr, 0);
    bus.ack = 1'b1; bus.rdy = 1'b1; bus.din = 16'h3C3C;
    tick();
    bus.ack = 1'b0; bus.rdy = 1'b0;
    check("t6_req_drop", bus.req, 0);
    check("t6_not_done_yet", done, 0);
    tick();
    check("t6_done", done, 1);
    check("t6_bad", bad, 0);
    check("t6_err", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
